// File: rtl/adder_operand_loader.sv
// Assembles operands A and B from narrow input beats, holds them for the adder
// to settle, then captures the adder sum and offers it on a valid/ready port.
module adder_operand_loader #(
  parameter int ANCHO  = 64,
  parameter int CHUNK  = 16,
  parameter int SETTLE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CHUNK-1:0]   in_data,
  output logic [ANCHO-1:0]   op_a,
  output logic [ANCHO-1:0]   op_b,
  input  logic [ANCHO:0]     sum_in,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [ANCHO:0]     res_data,
  output logic               busy
);

  localparam int NCHUNK = ANCHO / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);
  localparam logic [7:0]       CNT_LAST = 8'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_LOAD_A = 2'd0,
    ST_LOAD_B = 2'd1,
    ST_SETTLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [IDX_W-1:0]   idx_r, idx_nxt_s;
  logic [7:0]         cnt_r, cnt_nxt_s;
  logic [ANCHO-1:0]   op_a_r, op_b_r;
  logic [ANCHO:0]     res_data_r;
  logic               res_valid_r;
  logic               wr_a_s, wr_b_s, cap_s, clr_s;

  // Next-state decode and per-cycle write/capture strobes
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    cnt_nxt_s   = cnt_r;
    wr_a_s      = 1'b0;
    wr_b_s      = 1'b0;
    cap_s       = 1'b0;
    clr_s       = 1'b0;
    case (state_r)
      ST_LOAD_A: begin
        if (in_valid) begin
          wr_a_s = 1'b1;
          if (idx_r == IDX_LAST) begin
            idx_nxt_s   = '0;
            state_nxt_s = ST_LOAD_B;
          end else begin
            idx_nxt_s = idx_r + IDX_W'(1);
          end
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      ST_LOAD_B: begin
        if (in_valid) begin
          wr_b_s = 1'b1;
          if (idx_r == IDX_LAST) begin
            idx_nxt_s   = '0;
            cnt_nxt_s   = 8'd0;
            state_nxt_s = ST_SETTLE;
          end else begin
            idx_nxt_s = idx_r + IDX_W'(1);
          end
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      ST_SETTLE: begin
        if (cnt_r == CNT_LAST) begin
          cap_s       = 1'b1;
          cnt_nxt_s   = 8'd0;
          state_nxt_s = ST_HOLD;
        end else begin
          cnt_nxt_s = cnt_r + 8'd1;
        end
      end
      ST_HOLD: begin
        if (res_valid_r && res_ready) begin
          clr_s       = 1'b1;
          idx_nxt_s   = '0;
          state_nxt_s = ST_LOAD_A;
        end else begin
          clr_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = ST_LOAD_A;
        idx_nxt_s   = '0;
        cnt_nxt_s   = 8'd0;
      end
    endcase
  end

  // State, operand and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_LOAD_A;
      idx_r       <= '0;
      cnt_r       <= 8'd0;
      op_a_r      <= '0;
      op_b_r      <= '0;
      res_data_r  <= '0;
      res_valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (wr_a_s) op_a_r[idx_r*CHUNK +: CHUNK] <= in_data;
      if (wr_b_s) op_b_r[idx_r*CHUNK +: CHUNK] <= in_data;
      if (cap_s) begin
        res_data_r  <= sum_in;
        res_valid_r <= 1'b1;
      end else if (clr_s) begin
        res_valid_r <= 1'b0;
      end
    end
  end

  assign in_ready  = (state_r == ST_LOAD_A) || (state_r == ST_LOAD_B);
  assign busy      = (state_r == ST_SETTLE) || (state_r == ST_HOLD);
  assign op_a      = op_a_r;
  assign op_b      = op_b_r;
  assign res_data  = res_data_r;
  assign res_valid = res_valid_r;

endmodule
